// File: rtl/flex_aggregator_if.sv
// Sender/receiver handshake bundle for flex_aggregator.
// slave: the aggregator's view; master: the environment's view.
interface flex_aggregator_if #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FETCH  = 4
);
    localparam int CNT_W = $clog2(MAX_FETCH + 1);

    logic [DATA_WIDTH-1:0]           sender_data;
    logic                            sender_empty_n;
    logic                            sender_deq;
    logic [MAX_FETCH*DATA_WIDTH-1:0] receiver_data;
    logic [CNT_W-1:0]                receiver_count;
    logic                            receiver_full_n;
    logic                            receiver_enq;

    modport slave (
        input  sender_data,
        input  sender_empty_n,
        output sender_deq,
        output receiver_data,
        output receiver_count,
        input  receiver_full_n,
        output receiver_enq
    );

    modport master (
        output sender_data,
        output sender_empty_n,
        input  sender_deq,
        input  receiver_data,
        input  receiver_count,
        output receiver_full_n,
        input  receiver_enq
    );
endinterface

// File: rtl/flex_aggregator.sv
// Packs a stream of elements into words of cfg_len slots (flush emits
// partials). Ports: clk, rst_n (sync, active low), cfg_len, flush, bus.
module flex_aggregator #(
    parameter int DATA_WIDTH = 16,
    parameter int MAX_FETCH  = 4
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [$clog2(MAX_FETCH+1)-1:0]    cfg_len,
    input  logic                              flush,
    flex_aggregator_if.slave                  bus
);
    localparam int CNT_W = $clog2(MAX_FETCH + 1);

    typedef logic [MAX_FETCH-1:0][DATA_WIDTH-1:0] slots_t;

    slots_t                          slot_q;
    slots_t                          slot_d;
    logic [CNT_W-1:0]                asm_cnt_q;
    logic [CNT_W-1:0]                asm_len_q;
    logic                            asm_done_q;
    logic [MAX_FETCH*DATA_WIDTH-1:0] out_data_q;
    logic [CNT_W-1:0]                out_cnt_q;
    logic                            out_valid_q;

    logic             enq;
    logic             deq;
    logic             can_take;
    logic             asm_stall;
    logic             xfer_old;
    logic             new_done;
    logic             direct;
    logic [CNT_W-1:0] eff_len;
    logic [CNT_W-1:0] base_cnt;
    logic [CNT_W-1:0] cur_len;
    logic [CNT_W-1:0] ncnt;

    // Slots at or above cnt are forced to zero in the emitted word.
    function automatic slots_t mask_word(slots_t s, logic [CNT_W-1:0] cnt);
        slots_t w;
        w = '0;
        for (int i = 0; i < MAX_FETCH; i++) begin
            if (CNT_W'(i) < cnt) w[i] = s[i];
        end
        return w;
    endfunction

    always_comb begin
        eff_len = cfg_len;
        if (cfg_len == '0 || cfg_len > CNT_W'(MAX_FETCH)) begin
            eff_len = CNT_W'(MAX_FETCH);
        end
    end

    assign enq       = rst_n & out_valid_q & bus.receiver_full_n;
    assign can_take  = ~out_valid_q | enq;
    assign asm_stall = asm_done_q & ~can_take;
    assign deq       = rst_n & bus.sender_empty_n & ~asm_stall;

    // A stalled word leaving this cycle frees the assembly buffer,
    // so a new word can start at slot 0 in the same cycle.
    assign xfer_old = asm_done_q & can_take;
    assign base_cnt = xfer_old ? '0 : asm_cnt_q;
    assign cur_len  = (base_cnt == '0) ? eff_len : asm_len_q;
    assign ncnt     = base_cnt + {{(CNT_W-1){1'b0}}, deq};

    assign new_done = ~asm_stall
                    & ((deq & (ncnt == cur_len))
                    |  (flush & (ncnt != '0)));

    // A word completing now goes straight to the output buffer when it
    // is free, giving one cycle from the final deq to enq.
    assign direct = new_done & ~xfer_old & can_take;

    always_comb begin
        slot_d = slot_q;
        if (deq) begin
            for (int i = 0; i < MAX_FETCH; i++) begin
                if (base_cnt == CNT_W'(i)) slot_d[i] = bus.sender_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q      <= '0;
            asm_cnt_q   <= '0;
            asm_len_q   <= '0;
            asm_done_q  <= 1'b0;
            out_data_q  <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (!asm_stall) begin
                slot_q     <= slot_d;
                asm_cnt_q  <= direct ? '0 : ncnt;
                asm_done_q <= new_done & ~direct;
                if (deq && base_cnt == '0) asm_len_q <= eff_len;
            end
            if (xfer_old) begin
                out_data_q  <= mask_word(slot_q, asm_cnt_q);
                out_cnt_q   <= asm_cnt_q;
                out_valid_q <= 1'b1;
            end else if (direct) begin
                out_data_q  <= mask_word(slot_d, ncnt);
                out_cnt_q   <= ncnt;
                out_valid_q <= 1'b1;
            end else if (enq) begin
                out_data_q  <= '0;
                out_cnt_q   <= '0;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.sender_deq     = deq;
    assign bus.receiver_enq   = enq;
    assign bus.receiver_data  = out_data_q;
    assign bus.receiver_count = out_cnt_q;
endmodule

// File: tb/tb_flex_aggregator.sv
// Randomized and directed bench for flex_aggregator against a
// queue-based word-assembly model.
module tb_flex_aggregator;
    localparam int DW = 16;
    localparam int MF = 4;
    localparam int CW = $clog2(MF + 1);
    localparam int OW = MF * DW;

    typedef struct {
        logic [OW-1:0] d;
        int            c;
    } word_t;

    typedef struct {
        logic [OW-1:0] d;
        logic [CW-1:0] c;
        int            cyc;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] cfg_len = '0;
    logic          flush = 1'b0;

    flex_aggregator_if #(.DATA_WIDTH(DW), .MAX_FETCH(MF)) bus ();

    flex_aggregator #(.DATA_WIDTH(DW), .MAX_FETCH(MF)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .cfg_len (cfg_len),
        .flush   (flush),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_deq = 0;

    logic [DW-1:0] src[$];
    bit            offer = 1'b0;
    bit            full_n = 1'b1;

    word_t         words[$];
    logic [DW-1:0] part[$];
    int            plen = MF;
    rec_t          got[$];

    task automatic chk(string nm, logic [OW-1:0] act, logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    function automatic int eff(logic [CW-1:0] c);
        if (c == 0 || int'(c) > MF) return MF;
        return int'(c);
    endfunction

    // One clock cycle with the given flush and the current source state.
    task automatic step(input bit fl);
        flush = fl;
        bus.sender_empty_n = offer && (src.size() > 0);
        bus.sender_data = (src.size() > 0) ? src[0] : '0;
        bus.receiver_full_n = full_n;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    always @(negedge clk) begin
        bit    enq_e;
        bit    deq_e;
        bit    stall_e;
        word_t w;
        cyc++;
        if (!rst_n) begin
            chk("enq_in_reset", OW'(bus.receiver_enq), '0);
            chk("deq_in_reset", OW'(bus.sender_deq), '0);
            words.delete();
            part.delete();
        end else begin
            enq_e   = (words.size() > 0) && bus.receiver_full_n;
            stall_e = (words.size() == 2) && !enq_e;
            deq_e   = bus.sender_empty_n && !stall_e;
            chk("enq", OW'(bus.receiver_enq), OW'(enq_e));
            chk("deq", OW'(bus.sender_deq), OW'(deq_e));
            if (words.size() > 0) begin
                chk("data", bus.receiver_data, words[0].d);
                chk("count", OW'(bus.receiver_count), OW'(words[0].c));
            end
            if (bus.receiver_enq) begin
                got.push_back('{bus.receiver_data, bus.receiver_count, cyc});
            end
            if (bus.sender_deq) begin
                n_deq++;
                if (src.size() > 0) void'(src.pop_front());
            end
            if (enq_e) void'(words.pop_front());
            if (deq_e) begin
                if (part.size() == 0) plen = eff(cfg_len);
                part.push_back(bus.sender_data);
            end
            if ((deq_e && part.size() == plen) ||
                (flush && part.size() > 0)) begin
                w.d = '0;
                w.c = part.size();
                for (int i = 0; i < part.size(); i++) begin
                    w.d[i*DW +: DW] = part[i];
                end
                words.push_back(w);
                part.delete();
            end
        end
    end

    initial begin
        bus.sender_empty_n = 1'b0;
        bus.sender_data = '0;
        bus.receiver_full_n = 1'b1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        chk("reset_count", OW'(bus.receiver_count), '0);
        chk("reset_enq", OW'(bus.receiver_enq), '0);

        // Full-length word with cfg_len=0.
        got.delete();
        cfg_len = 0;
        full_n = 1;
        offer = 1;
        for (int i = 1; i <= 4; i++) src.push_back(DW'(i));
        run(8);
        chk("w4_n", OW'(got.size()), 1);
        if (got.size() >= 1) begin
            chk("w4_d", got[0].d, 64'h0004_0003_0002_0001);
            chk("w4_c", OW'(got[0].c), 4);
        end

        // cfg_len=3, two words.
        got.delete();
        cfg_len = 3;
        for (int i = 10; i <= 15; i++) src.push_back(DW'(i));
        run(10);
        chk("w3_n", OW'(got.size()), 2);
        if (got.size() >= 2) begin
            chk("w3a_d", got[0].d, 64'h0000_000C_000B_000A);
            chk("w3b_d", got[1].d, 64'h0000_000F_000E_000D);
            chk("w3_c", OW'(got[1].c), 3);
        end

        // Flush a partial word, then an idle flush.
        got.delete();
        cfg_len = 0;
        src.push_back(16'h11);
        src.push_back(16'h22);
        run(4);
        step(1'b1);
        run(3);
        chk("fl_n", OW'(got.size()), 1);
        if (got.size() >= 1) begin
            chk("fl_d", got[0].d, 64'h0000_0000_0022_0011);
            chk("fl_c", OW'(got[0].c), 2);
        end
        step(1'b1);
        run(3);
        chk("fl_empty", OW'(got.size()), 1);

        // Flush in the same cycle as a deq.
        got.delete();
        src.push_back(16'h44);
        run(3);
        src.push_back(16'h55);
        step(1'b1);
        run(3);
        chk("fd_n", OW'(got.size()), 1);
        if (got.size() >= 1) begin
            chk("fd_d", got[0].d, 64'h0000_0000_0055_0044);
            chk("fd_c", OW'(got[0].c), 2);
        end

        // Backpressure: two words held, ninth element blocked.
        got.delete();
        cfg_len = 4;
        full_n = 0;
        n_deq = 0;
        for (int i = 1; i <= 9; i++) src.push_back(DW'(16'h100 + i));
        run(20);
        chk("bp_deqs", OW'(n_deq), 8);
        chk("bp_left", OW'(src.size()), 1);
        chk("bp_noenq", OW'(got.size()), 0);
        full_n = 1;
        run(4);
        step(1'b1);
        run(3);
        chk("bp_n", OW'(got.size()), 3);
        if (got.size() >= 3) begin
            chk("bp_a", got[0].d, 64'h0104_0103_0102_0101);
            chk("bp_b", got[1].d, 64'h0108_0107_0106_0105);
            chk("bp_gap", OW'(got[1].cyc - got[0].cyc), 1);
            chk("bp_c", got[2].d, 64'h0000_0000_0000_0109);
            chk("bp_cc", OW'(got[2].c), 1);
        end

        // Reset mid-word discards the partial.
        got.delete();
        for (int i = 1; i <= 3; i++) src.push_back(DW'(16'h200 + i));
        run(5);
        rst_n = 0;
        src.delete();
        step(1'b0);
        rst_n = 1;
        run(4);
        chk("rs_noenq", OW'(got.size()), 0);
        for (int i = 1; i <= 4; i++) src.push_back(DW'(16'h300 + i));
        run(8);
        chk("rs_n", OW'(got.size()), 1);
        if (got.size() >= 1) begin
            chk("rs_d", got[0].d, 64'h0304_0303_0302_0301);
            chk("rs_c", OW'(got[0].c), 4);
        end

        // Randomized traffic checked by the model every cycle.
        for (int i = 0; i < 3000; i++) begin
            while (src.size() < 4) src.push_back(DW'($urandom));
            if ($urandom_range(0, 7) == 0) cfg_len = CW'($urandom_range(0, 7));
            offer  = ($urandom_range(0, 3) != 0);
            full_n = ($urandom_range(0, 2) != 0);
            rst_n  = ($urandom_range(0, 199) != 0);
            step($urandom_range(0, 9) == 0);
        end
        rst_n = 1;
        offer = 0;
        full_n = 1;
        run(6);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/flex_aggregator.md
FLEX_AGGREGATOR -- requirements
Module: flex_aggregator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, giving the bit width of one input element.
REQ-002 SHALL have parameter MAX_FETCH, default 4, giving the maximum number of elements per output word (legal range 2..64).
REQ-003 SHALL define localparam CNT_W = $clog2(MAX_FETCH+1).
REQ-004 SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-006 SHALL have port cfg_len, input, CNT_W bits: elements per word; values 0 and >MAX_FETCH are treated as MAX_FETCH.
REQ-007 SHALL have port flush, input, 1 bit: single-cycle request to emit the current partial word.
REQ-008 SHALL have port sender_data, input, DATA_WIDTH bits: the input element.
REQ-009 SHALL have port sender_empty_n, input, 1 bit: sender holds valid data.
REQ-010 SHALL have port sender_deq, output, 1 bit: element consumed this cycle (combinational).
REQ-011 SHALL have port receiver_data, output, MAX_FETCH*DATA_WIDTH bits: packed word, with slot i at bits [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH].
REQ-012 SHALL have port receiver_count, output, CNT_W bits: number of valid slots in receiver_data.
REQ-013 SHALL have port receiver_full_n, input, 1 bit: receiver can accept a word.
REQ-014 SHALL have port receiver_enq, output, 1 bit: word transferred this cycle (combinational).

Function
REQ-015 SHALL hold two registered stages: an assembly buffer (slots, count, latched length) and an output buffer (data, count, out_valid).
REQ-016 SHALL drive receiver_enq = rst_n & out_valid & receiver_full_n; the output buffer clears on enq unless it is reloaded in the same cycle.
REQ-017 SHALL drive sender_deq = rst_n & sender_empty_n & ~asm_stall, where asm_stall = the assembly buffer is complete and the output buffer cannot take it this cycle.
REQ-018 SHALL consider the output buffer able to take a word when out_valid=0 or receiver_enq=1 in the same cycle.
REQ-019 SHALL latch the effective cfg_len into the assembly length when a deq occurs with count=0; cfg_len changes mid-word SHALL be ignored.
REQ-020 SHALL write the dequeued element to slot[count] and increment count.
REQ-021 SHALL mark the word complete when the post-increment count equals the latched length, or when flush=1 with a post-update count >0.
REQ-022 SHALL move a complete word to the output buffer in the cycle after its final deq when the output buffer can take it; otherwise the word SHALL wait, with sender_deq held low.
REQ-023 SHALL zero all slots at indices >= count in the transferred word; receiver_count SHALL equal the word's count.
REQ-024 SHALL include an element dequeued in the same cycle as flush in the flushed word.
REQ-025 SHALL treat flush with count=0 and no deq as a no-op, producing no empty word.
REQ-026 SHALL latch a flush that arrives while a complete word is stalled as a no-op, since the word is already complete.
REQ-027 SHALL, after a transfer, reset assembly count to 0 so a new word may begin with a deq in the same transfer cycle.
REQ-028 SHALL sustain one element per cycle with receiver_full_n held high; latency from the final element's deq to receiver_enq SHALL be 1 cycle.
REQ-029 SHALL keep receiver_data/receiver_count stable while out_valid=1 and receiver_full_n=0.

Reset
REQ-030 SHALL, while rst_n=0 at a clock edge, clear assembly count, out_valid, receiver_count and all slot registers to 0.
REQ-031 SHALL hold sender_deq=0 and receiver_enq=0 combinationally while rst_n=0.
REQ-032 SHALL discard partial and pending words on reset mid-operation, with no enq afterwards until new data completes a word.

Verification
REQ-033 SHALL verify: DATA_WIDTH=16, MAX_FETCH=4, cfg_len=0, sender feeds 1,2,3,4 back-to-back, full_n=1 -> one enq the cycle after the 4th deq, data=0x0004_0003_0002_0001, count=4.
REQ-034 SHALL verify: cfg_len=3, feed 0xA,0xB,0xC,0xD,0xE,0xF -> two enqs, words 0x0000_000C_000B_000A and 0x0000_000F_000E_000D, count=3 each.
REQ-035 SHALL verify: feed 0x11,0x22 then flush with no data -> one enq, data=0x0000_0000_0022_0011, count=2; a second flush -> no enq.
REQ-036 SHALL verify: receiver_full_n=0 while 9 elements are offered with cfg_len=4 -> exactly 8 deqs then sender_deq=0; output word stable; raising full_n -> two words in consecutive cycles, no loss or reordering.
REQ-037 SHALL verify: flush coinciding with deq of 0x55 at count=1 (slot0=0x44) -> word 0x0000_0000_0055_0044, count=2.
REQ-038 SHALL verify: rst_n=0 for one cycle after 3 of 4 elements -> no enq; the next 4 elements form a clean word with count=4.
